misrc_sample_packer: RTL and testbench



---
 rtl/misrc_sample_packer.sv | 163 ++++++++++++++++
 tb/tb_misrc_sample_packer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/misrc_sample_packer.sv
// Packs 12-bit ADC samples plus flag bits into 32-bit FIFO words, with overflow tracking.
// Optional macro MISRC_TEST_PATTERN_EN adds a counter-based test pattern source.
module misrc_sample_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_adc,
    input  logic             rstn,
    input  logic [11:0]      adc_a,
    input  logic [11:0]      adc_b,
    input  logic [1:0]       aux,
`ifdef MISRC_TEST_PATTERN_EN
    input  logic             test_pattern,
`endif
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic             fifo_full,
    output logic [31:0]      fifo_wr_data,
    output logic             fifo_wr_en,
    output logic             dword_enable_out,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             ovf
);

    typedef enum logic {S0 = 1'b0, S1 = 1'b1} pack_state_t;

    pack_state_t      state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [15:0]      low_q, low_d;
    logic             povf_q, povf_d;
    logic [31:0]      data_q, data_d;
    logic             wr_en_q, wr_en_d;
    logic             dword_q, dword_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;

    logic [11:0]      smp_a, smp_b;
    logic [1:0]       smp_aux;
    logic [15:0]      hw_a, hw_b;
    logic [1:0]       eff_mode;
    logic             boundary, complete;
    logic [31:0]      word;

    function automatic logic [15:0] half_word(input logic [11:0] s, input logic [1:0] x);
        return {(s == 12'h000) || (s == 12'hFFF), 1'b0, x, s};
    endfunction

`ifdef MISRC_TEST_PATTERN_EN
    logic [11:0] tp_cnt_q;

    always_ff @(posedge clk_adc or negedge rstn) begin
        if (!rstn) begin
            tp_cnt_q <= '0;
        end else if (in_valid && test_pattern) begin
            tp_cnt_q <= tp_cnt_q + 12'd1;
        end
    end

    always_comb begin
        smp_a   = test_pattern ? tp_cnt_q : adc_a;
        smp_b   = test_pattern ? ~tp_cnt_q : adc_b;
        smp_aux = test_pattern ? 2'b00 : aux;
    end
`else
    always_comb begin
        smp_a   = adc_a;
        smp_b   = adc_b;
        smp_aux = aux;
    end
`endif

    assign hw_a = half_word(smp_a, smp_aux);
    assign hw_b = half_word(smp_b, smp_aux);

    // The mode presented on a word boundary governs that word immediately.
    assign boundary = in_valid && (state_q == S0);
    assign eff_mode = boundary ? mode : mode_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dword_d  = dword_q;
        low_d    = low_q;
        complete = 1'b0;
        word     = '0;
        if (in_valid) begin
            if (boundary) begin
                mode_d  = mode;
                dword_d = (mode != 2'd0);
            end
            unique case (eff_mode)
                2'd0: begin
                    complete = 1'b1;
                    word     = {16'h0000, hw_a};
                end
                2'd1: begin
                    if (state_q == S0) begin
                        low_d   = hw_a;
                        state_d = S1;
                    end else begin
                        complete = 1'b1;
                        word     = {hw_a, low_q};
                        state_d  = S0;
                    end
                end
                default: begin
                    complete = 1'b1;
                    word     = {hw_b, hw_a};
                end
            endcase
        end
    end

    // povf is merged into bit 14 (low half-word) only when the word is actually written.
    always_comb begin
        wr_en_d = 1'b0;
        data_d  = data_q;
        povf_d  = povf_q;
        drop_d  = drop_q;
        ovf_d   = ovf_q;
        if (complete) begin
            if (fifo_full) begin
                drop_d = (drop_q == '1) ? drop_q : drop_q + CNT_W'(1);
                povf_d = 1'b1;
                ovf_d  = 1'b1;
            end else begin
                wr_en_d = 1'b1;
                data_d  = word | {17'b0, povf_q, 14'b0};
                povf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_adc or negedge rstn) begin
        if (!rstn) begin
            state_q <= S0;
            mode_q  <= '0;
            low_q   <= '0;
            povf_q  <= 1'b0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            dword_q <= 1'b0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            low_q   <= low_d;
            povf_q  <= povf_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            dword_q <= dword_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    assign fifo_wr_data     = data_q;
    assign fifo_wr_en       = wr_en_q;
    assign dword_enable_out = dword_q;
    assign drop_cnt         = drop_q;
    assign ovf              = ovf_q;

endmodule

// File: tb/tb_misrc_sample_packer.sv
// Self-checking bench for misrc_sample_packer: directed cases plus randomized traffic vs. a behavioural model.
module tb_misrc_sample_packer;

    localparam int CNT_W = 4;

    logic             clk_adc = 1'b0;
    logic             rstn = 1'b0;
    logic [11:0]      adc_a = '0;
    logic [11:0]      adc_b = '0;
    logic [1:0]       aux = '0;
    logic             in_valid = 1'b0;
    logic [1:0]       mode = '0;
    logic             fifo_full = 1'b0;
    logic [31:0]      fifo_wr_data;
    logic             fifo_wr_en;
    logic             dword_enable_out;
    logic [CNT_W-1:0] drop_cnt;
    logic             ovf;

    int unsigned errors = 0;
    int unsigned checks = 0;

    misrc_sample_packer #(.CNT_W(CNT_W)) dut (
        .clk_adc          (clk_adc),
        .rstn             (rstn),
        .adc_a            (adc_a),
        .adc_b            (adc_b),
        .aux              (aux),
`ifdef MISRC_TEST_PATTERN_EN
        .test_pattern     (1'b0),
`endif
        .in_valid         (in_valid),
        .mode             (mode),
        .fifo_full        (fifo_full),
        .fifo_wr_data     (fifo_wr_data),
        .fifo_wr_en       (fifo_wr_en),
        .dword_enable_out (dword_enable_out),
        .drop_cnt         (drop_cnt),
        .ovf              (ovf)
    );

    always #5 clk_adc = ~clk_adc;

    // Behavioural model: a word is assembled from a list of half-words.
    int          m_mode;
    logic [15:0] m_held[$];
    bit          m_povf, m_ovf, m_dw, m_en;
    int          m_drops;
    logic [31:0] m_data;

    function automatic logic [15:0] hw(input logic [11:0] s, input logic [1:0] x);
        logic [15:0] h;
        h = {4'b0000, s};
        h[13:12] = x;
        if (s == 12'h000 || s == 12'hFFF) h[15] = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_held.delete(); m_povf = 0; m_ovf = 0; m_dw = 0;
        m_en = 0; m_drops = 0; m_data = '0;
    endtask

    task automatic model_step();
        logic [31:0] w;
        bit done;
        m_en = 0;
        done = 0;
        w = '0;
        if (in_valid) begin
            if (m_held.size() == 0) begin
                m_mode = (mode == 2'd3) ? 2 : int'(mode);
                m_dw = (mode != 2'd0);
            end
            if (m_mode == 0) begin
                w = {16'h0000, hw(adc_a, aux)};
                done = 1;
            end else if (m_mode == 1) begin
                m_held.push_back(hw(adc_a, aux));
                if (m_held.size() == 2) begin
                    w = {m_held[1], m_held[0]};
                    m_held.delete();
                    done = 1;
                end
            end else begin
                w = {hw(adc_b, aux), hw(adc_a, aux)};
                done = 1;
            end
        end
        if (done) begin
            if (fifo_full) begin
                if (m_drops < (1 << CNT_W) - 1) m_drops++;
                m_povf = 1;
                m_ovf = 1;
            end else begin
                if (m_povf) w = w + 32'h0000_4000;
                m_data = w;
                m_en = 1;
                m_povf = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("wr_en", {31'b0, fifo_wr_en}, {31'b0, m_en});
        if (m_en) chk("wr_data", fifo_wr_data, m_data);
        chk("dword_en", {31'b0, dword_enable_out}, {31'b0, m_dw});
        chk("drop_cnt", {28'b0, drop_cnt}, 32'(m_drops));
        chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    endtask

    task automatic cyc(input bit v, input logic [11:0] a, input logic [11:0] b,
                       input logic [1:0] x, input logic [1:0] md, input bit full);
        @(negedge clk_adc);
        in_valid = v; adc_a = a; adc_b = b; aux = x; mode = md; fifo_full = full;
        @(posedge clk_adc);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk_adc);
        rstn = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_data", fifo_wr_data, 32'h0);
        @(negedge clk_adc);
        rstn = 1'b1;
    endtask

    function automatic logic [11:0] rnd_sample();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 12'h000;
        if (r == 1) return 12'hFFF;
        return 12'($urandom);
    endfunction

    initial begin
        model_reset();
        do_reset();

        // Dual mode single sample
        cyc(1, 12'h123, 12'h456, 2'b01, 2'd2, 0);
        chk("t1_data", fifo_wr_data, 32'h1456_1123);
        chk("t1_dw", {31'b0, dword_enable_out}, 32'd1);

        // Packed mode, clip on second sample
        do_reset();
        cyc(1, 12'h00A, 12'h000, 2'b00, 2'd1, 0);
        chk("t2_nowr", {31'b0, fifo_wr_en}, 32'd0);
        cyc(1, 12'hFFF, 12'h000, 2'b00, 2'd1, 0);
        chk("t2_data", fifo_wr_data, 32'h8FFF_000A);

        // Mode switch mid-word
        cyc(1, 12'h011, 12'h022, 2'b00, 2'd1, 0);
        cyc(1, 12'h033, 12'h044, 2'b00, 2'd2, 0);
        chk("t3_packed", fifo_wr_data, 32'h0033_0011);
        cyc(1, 12'h055, 12'h066, 2'b00, 2'd2, 0);
        chk("t3_dual", fifo_wr_data, 32'h0066_0055);
        chk("t3_dw", {31'b0, dword_enable_out}, 32'd1);

        // Overflow with povf insertion
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 12'h3A5, 12'h0, 2'b00, 2'd0, 1);
        cyc(0, 12'h0, 12'h0, 2'b00, 2'd0, 0);
        cyc(1, 12'h100, 12'h0, 2'b00, 2'd0, 0);
        chk("t4_data", fifo_wr_data, 32'h0000_4100);
        chk("t4_drop", {28'b0, drop_cnt}, 32'd3);
        chk("t4_ovf", {31'b0, ovf}, 32'd1);
        cyc(1, 12'h200, 12'h0, 2'b00, 2'd0, 0);
        chk("t4_next", fifo_wr_data, 32'h0000_0200);

        // Saturation
        do_reset();
        for (int i = 0; i < 17; i++) cyc(1, 12'h123, 12'h0, 2'b00, 2'd0, 1);
        chk("t5_sat", {28'b0, drop_cnt}, 32'hF);

        // Randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc($urandom_range(0, 9) < 7, rnd_sample(), rnd_sample(), 2'($urandom),
                2'($urandom), $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
